apb4_gpio_irq: RTL and testbench

- Parametrised successor to the 8-pin APB4 GPIO: GPIO_NUM pins, per-pin direction/output/input registers.
- Adds input synchronisation, optional per-pin debounce, and per-pin edge/level interrupts with a single combined irq_o line.
- APB4 slave on the peripheral bus. Zero-wait-state accesses.

---
 rtl/apb4_gpio_irq_pkg.sv | 40 ++++
 rtl/apb4_gpio_irq_if.sv | 22 ++
 rtl/apb4_gpio_irq_filter.sv | 51 +++++
 rtl/apb4_gpio_irq.sv | 132 +++++++++++++
 tb/tb_apb4_gpio_irq.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb4_gpio_irq_pkg.sv
// Shared register map and decode helper for the APB4 GPIO with interrupts.
package gpio_irq_pkg;

    localparam int OFS_W = 4;

    // Word offsets, taken from paddr[5:2]
    localparam logic [OFS_W-1:0] GPIO_DIR     = 4'h0;
    localparam logic [OFS_W-1:0] GPIO_OUT     = 4'h1;
    localparam logic [OFS_W-1:0] GPIO_IN      = 4'h2;
    localparam logic [OFS_W-1:0] GPIO_OUTSET  = 4'h3;
    localparam logic [OFS_W-1:0] GPIO_OUTCLR  = 4'h4;
    localparam logic [OFS_W-1:0] GPIO_INTEN   = 4'h5;
    localparam logic [OFS_W-1:0] GPIO_INTTYPE = 4'h6;
    localparam logic [OFS_W-1:0] GPIO_INTPOL  = 4'h7;
    localparam logic [OFS_W-1:0] GPIO_INTSTAT = 4'h8;
    localparam logic [OFS_W-1:0] GPIO_DBCEN   = 4'h9;
    localparam logic [OFS_W-1:0] GPIO_DBCDIV  = 4'hA;

    typedef enum logic [OFS_W-1:0] {
        REG_DIR     = 4'h0,
        REG_OUT     = 4'h1,
        REG_IN      = 4'h2,
        REG_OUTSET  = 4'h3,
        REG_OUTCLR  = 4'h4,
        REG_INTEN   = 4'h5,
        REG_INTTYPE = 4'h6,
        REG_INTPOL  = 4'h7,
        REG_INTSTAT = 4'h8,
        REG_DBCEN   = 4'h9,
        REG_DBCDIV  = 4'hA,
        REG_NONE    = 4'hF
    } reg_idx_e;

    // Offsets past the last register collapse to REG_NONE
    function automatic reg_idx_e reg_decode(input logic [OFS_W-1:0] ofs);
        if (ofs > GPIO_DBCDIV) return REG_NONE;
        return reg_idx_e'(ofs);
    endfunction

endpackage

// File: rtl/apb4_gpio_irq_if.sv
// APB4 slave-side signal bundle for the GPIO block.
interface apb4_gpio_irq_if;
    logic [11:0] paddr_i;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport slave (
        input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb4_gpio_irq_filter.sv
// One pin: synchroniser, optional two-tick debounce, edge detect.
module gpio_irq_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin,
    input  logic tick,
    input  logic dbc_en,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   hist;
    logic                   prev;

    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous pad
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    // Debounce: accept a new level only after two equal tick samples
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist <= 1'b0;
            filt <= 1'b0;
        end else if (!dbc_en) begin
            hist <= sync;
            filt <= sync;
        end else if (tick) begin
            hist <= sync;
            if (sync == hist) filt <= sync;
        end
    end

    // Previous filtered value for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) prev <= 1'b0;
        else          prev <= filt;
    end

    assign rise = filt & ~prev;
    assign fall = ~filt & prev;

endmodule

// File: rtl/apb4_gpio_irq.sv
// APB4 GPIO with per-pin debounce and edge/level interrupts.
module apb4_gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int GPIO_NUM    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DBC_DIV_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    apb4_gpio_irq_if.slave      apb,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_dir_o,
    output logic                irq_o
);

    logic [GPIO_NUM-1:0]  dir, out, inten, inttype, intpol, intstat, dbcen;
    logic [DBC_DIV_W-1:0] dbcdiv, cnt;
    logic [GPIO_NUM-1:0]  filt, rise, fall, evt, clr;
    logic [GPIO_NUM-1:0]  wmask, wbits;
    logic [DBC_DIV_W-1:0] dmask;
    logic [31:0]          bmask, rdata;
    logic                 access, bad, wr_en, tick;
    reg_idx_e             idx;
    logic                 unused_ok;

    // Bus decode: a bad access raises pslverr and changes nothing
    assign idx    = reg_decode(apb.paddr_i[5:2]);
    assign access = apb.psel_i & apb.penable_i;
    assign bad    = (idx == REG_NONE) || (apb.pwrite_i && idx == REG_IN);
    assign wr_en  = access & apb.pwrite_i & ~bad;

    assign bmask  = {{8{apb.pstrb_i[3]}}, {8{apb.pstrb_i[2]}},
                     {8{apb.pstrb_i[1]}}, {8{apb.pstrb_i[0]}}};
    assign wmask  = bmask[GPIO_NUM-1:0];
    assign wbits  = apb.pwdata_i[GPIO_NUM-1:0] & wmask;
    assign dmask  = bmask[DBC_DIV_W-1:0];

    assign apb.pready_o  = 1'b1;
    assign apb.pslverr_o = access & bad;
    assign apb.prdata_o  = (access && !apb.pwrite_i) ? rdata : '0;

    assign unused_ok = &{1'b0, apb.paddr_i, apb.pwdata_i, bmask};

    // Read mux; unused upper bits and write-only registers read 0
    always_comb begin
        rdata = '0;
        case (idx)
            REG_DIR:     rdata[GPIO_NUM-1:0]  = dir;
            REG_OUT:     rdata[GPIO_NUM-1:0]  = out;
            REG_IN:      rdata[GPIO_NUM-1:0]  = filt;
            REG_INTEN:   rdata[GPIO_NUM-1:0]  = inten;
            REG_INTTYPE: rdata[GPIO_NUM-1:0]  = inttype;
            REG_INTPOL:  rdata[GPIO_NUM-1:0]  = intpol;
            REG_INTSTAT: rdata[GPIO_NUM-1:0]  = intstat;
            REG_DBCEN:   rdata[GPIO_NUM-1:0]  = dbcen;
            REG_DBCDIV:  rdata[DBC_DIV_W-1:0] = dbcdiv;
            default:     rdata = '0;
        endcase
    end

    // Register file writes, honouring byte strobes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dir     <= '0;
            out     <= '0;
            inten   <= '0;
            inttype <= '0;
            intpol  <= '0;
            dbcen   <= '0;
            dbcdiv  <= '0;
        end else if (wr_en) begin
            case (idx)
                REG_DIR:     dir     <= (dir & ~wmask) | wbits;
                REG_OUT:     out     <= (out & ~wmask) | wbits;
                REG_OUTSET:  out     <= out | wbits;
                REG_OUTCLR:  out     <= out & ~wbits;
                REG_INTEN:   inten   <= (inten & ~wmask) | wbits;
                REG_INTTYPE: inttype <= (inttype & ~wmask) | wbits;
                REG_INTPOL:  intpol  <= (intpol & ~wmask) | wbits;
                REG_DBCEN:   dbcen   <= (dbcen & ~wmask) | wbits;
                REG_DBCDIV:  dbcdiv  <= (dbcdiv & ~dmask) |
                                        (apb.pwdata_i[DBC_DIV_W-1:0] & dmask);
                default: ;
            endcase
        end
    end

    assign tick = (cnt == dbcdiv);

    // Debounce prescaler; a DBCDIV write restarts the count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                        cnt <= '0;
        else if (wr_en && idx == REG_DBCDIV) cnt <= '0;
        else if (tick)                       cnt <= '0;
        else                                 cnt <= cnt + 1'b1;
    end

    for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
        gpio_irq_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filt (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .pin    (gpio_in_i[g]),
            .tick   (tick),
            .dbc_en (dbcen[g]),
            .filt   (filt[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    assign evt = (inttype & ((intpol & rise) | (~intpol & fall)))
               | (~inttype & ~(filt ^ intpol));
    assign clr = (wr_en && idx == REG_INTSTAT) ? wbits : '0;

    // Sticky status; a new event outranks a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) intstat <= '0;
        else          intstat <= (intstat & ~clr) | evt;
    end

    // Combined interrupt, one cycle behind the status
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) irq_o <= 1'b0;
        else          irq_o <= |(intstat & inten);
    end

    assign gpio_out_o = out;
    assign gpio_dir_o = dir;

endmodule

// File: tb/tb_apb4_gpio_irq.sv
// Bench for apb4_gpio_irq: directed APB/pad stimulus, per-cycle model compare.
module tb_apb4_gpio_irq;
    localparam int N  = 8;
    localparam int SS = 2;
    localparam int DW = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pad = '0;
    logic [N-1:0] gout, gdir;
    logic         irq;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    apb4_gpio_irq_if apb();

    apb4_gpio_irq #(.GPIO_NUM(N), .SYNC_STAGES(SS), .DBC_DIV_W(DW)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .apb       (apb),
        .gpio_in_i (pad),
        .gpio_out_o(gout),
        .gpio_dir_o(gdir),
        .irq_o     (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [N-1:0]  m_dir, m_out, m_inten, m_type, m_pol, m_stat, m_dbcen;
    bit [N-1:0]  m_filt, m_hist, m_prev;
    bit [DW-1:0] m_div, m_cnt;
    bit          m_irq;
    bit [N-1:0]  padq [SS];   // padq[k]: pad value captured k+1 edges ago

    function automatic bit m_err(input logic [11:0] a, input logic w);
        return (a[5:2] > 4'hA) || (w && a[5:2] == 4'h2);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] r;
        r = '0;
        case (a[5:2])
            4'h0: r[N-1:0]  = m_dir;
            4'h1: r[N-1:0]  = m_out;
            4'h2: r[N-1:0]  = m_filt;
            4'h5: r[N-1:0]  = m_inten;
            4'h6: r[N-1:0]  = m_type;
            4'h7: r[N-1:0]  = m_pol;
            4'h8: r[N-1:0]  = m_stat;
            4'h9: r[N-1:0]  = m_dbcen;
            4'hA: r[DW-1:0] = m_div;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_step();
        bit          tick, w, f, p;
        bit [N-1:0]  sync, ev, nf, nh, wm, wd, clr;
        bit [31:0]   be;
        int          r;
        if (!rst_n) begin
            {m_dir, m_out, m_inten, m_type, m_pol, m_stat, m_dbcen} = '0;
            {m_filt, m_hist, m_prev} = '0;
            m_div = '0; m_cnt = '0; m_irq = 1'b0;
            for (int k = 0; k < SS; k++) padq[k] = '0;
            return;
        end
        tick = (m_cnt == m_div);
        sync = padq[SS-1];
        r    = int'(apb.paddr_i[5:2]);
        w    = apb.psel_i && apb.penable_i && apb.pwrite_i && !m_err(apb.paddr_i, 1'b1);
        for (int b = 0; b < 4; b++) be[8*b +: 8] = {8{apb.pstrb_i[b]}};
        wm = be[N-1:0];
        wd = apb.pwdata_i[N-1:0] & wm;
        for (int i = 0; i < N; i++) begin
            f = m_filt[i];
            p = m_prev[i];
            if (m_type[i]) ev[i] = m_pol[i] ? (f && !p) : (!f && p);
            else           ev[i] = (f == m_pol[i]);
            nf[i] = m_filt[i];
            nh[i] = m_hist[i];
            if (!m_dbcen[i]) begin
                nf[i] = sync[i];
                nh[i] = sync[i];
            end else if (tick) begin
                nh[i] = sync[i];
                if (sync[i] == m_hist[i]) nf[i] = sync[i];
            end
        end
        clr    = (w && r == 8) ? wd : '0;
        m_irq  = |(m_stat & m_inten);
        m_stat = (m_stat & ~clr) | ev;
        m_prev = m_filt;
        m_filt = nf;
        m_hist = nh;
        m_cnt  = (w && r == 10) ? '0 : (tick ? '0 : m_cnt + 1'b1);
        if (w) begin
            case (r)
                0:  m_dir   = (m_dir & ~wm) | wd;
                1:  m_out   = (m_out & ~wm) | wd;
                3:  m_out   = m_out | wd;
                4:  m_out   = m_out & ~wd;
                5:  m_inten = (m_inten & ~wm) | wd;
                6:  m_type  = (m_type & ~wm) | wd;
                7:  m_pol   = (m_pol & ~wm) | wd;
                9:  m_dbcen = (m_dbcen & ~wm) | wd;
                10: m_div   = (m_div & ~be[DW-1:0]) | (apb.pwdata_i[DW-1:0] & be[DW-1:0]);
                default: ;
            endcase
        end
        for (int k = SS - 1; k > 0; k--) padq[k] = padq[k-1];
        padq[0] = pad;
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // Per-cycle compare of every output against the model
    initial begin : compare
        logic acc;
        forever begin
            @(negedge clk);
            acc = apb.psel_i && apb.penable_i;
            chk("gpio_out", 32'(gout), 32'(m_out));
            chk("gpio_dir", 32'(gdir), 32'(m_dir));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("pready", 32'(apb.pready_o), 32'h1);
            chk("pslverr", 32'(apb.pslverr_o),
                32'(acc && m_err(apb.paddr_i, apb.pwrite_i)));
            chk("prdata", apb.prdata_o,
                (acc && !apb.pwrite_i) ? m_read(apb.paddr_i) : 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the access phase
    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic err);
        apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
        apb.paddr_i = a; apb.pwdata_i = d; apb.pstrb_i = s;
        @(posedge clk); #1;
        apb.penable_i = 1'b1;
        @(negedge clk);
        rd = apb.prdata_o;
        err = apb.pslverr_o;
        @(posedge clk); #1;
        apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
    endtask

    task automatic wrs(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, a, d, s, rd, err);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wrs(a, d, 4'hF);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, a, 32'h0, 4'h0, rd, err);
        chk(name, rd, exp);
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        err;
        apb.psel_i = 0; apb.penable_i = 0; apb.pwrite_i = 0;
        apb.paddr_i = '0; apb.pwdata_i = '0; apb.pstrb_i = '0;

        // Reset values
        #1;
        chk("rst_out", 32'(gout), 32'h0);
        chk("rst_dir", 32'(gdir), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_prdata", apb.prdata_o, 32'h0);
        chk("rst_pslverr", 32'(apb.pslverr_o), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // All registers zero, except INTSTAT: default level-low mode with pins low sets every bit
        for (int a = 0; a <= 10; a++)
            rd_chk($sformatf("reset_reg_%0d", a), 12'(a * 4), (a == 8) ? 32'hFF : 32'h0);
        chk("irq_after_reset", 32'(irq), 32'h0);
        apb_xfer(1'b0, 12'h03C, 32'h0, 4'h0, rd, err);
        chk("unmapped_err", 32'(err), 32'h1);

        // Output registers
        wr(12'h000, 32'hFFFF_FFFF);
        wr(12'h004, 32'hA5);
        wr(12'h00C, 32'h0A);
        wr(12'h010, 32'h80);
        chk("out_set_clr", 32'(gout), 32'h2F);
        chk("dir_pins", 32'(gdir), 32'hFF);
        rd_chk("dir_upper_zero", 12'h000, 32'hFF);
        wrs(12'h004, 32'hFF, 4'b1110);
        rd_chk("out_strobe_off", 12'h004, 32'h2F);
        rd_chk("outset_reads0", 12'h00C, 32'h0);
        apb_xfer(1'b1, 12'h008, 32'hFF, 4'hF, rd, err);
        chk("in_write_err", 32'(err), 32'h1);
        rd_chk("in_unchanged", 12'h008, 32'h0);

        // Rising-edge interrupt on pin 0
        wr(12'h018, 32'hFF);
        wr(12'h01C, 32'h01);
        wr(12'h020, 32'hFF);
        rd_chk("stat_cleared", 12'h020, 32'h0);
        wr(12'h014, 32'h01);
        pad[0] = 1'b1;
        rd_chk("in0_early", 12'h008, 32'h0);
        rd_chk("in0_at3", 12'h008, 32'h1);
        chk("irq_not_yet", 32'(irq), 32'h0);
        cyc(1);
        chk("irq_edge", 32'(irq), 32'h1);
        rd_chk("stat_edge", 12'h020, 32'h01);
        wr(12'h020, 32'h01);
        chk("irq_lag_clear", 32'(irq), 32'h1);
        cyc(1);
        chk("irq_cleared", 32'(irq), 32'h0);
        pad[0] = 1'b0;
        cyc(6);
        rd_chk("no_fall_evt", 12'h020, 32'h0);

        // Level-low on pin 3: clear cannot win while the level holds
        wr(12'h018, 32'hF7);
        wr(12'h014, 32'h08);
        cyc(3);
        chk("irq_level", 32'(irq), 32'h1);
        wr(12'h020, 32'h08);
        chk("irq_level_hold0", 32'(irq), 32'h1);
        cyc(1);
        chk("irq_level_hold1", 32'(irq), 32'h1);
        rd_chk("stat_level", 12'h020, 32'h08);
        wr(12'h014, 32'h00);
        wr(12'h018, 32'hFF);
        wr(12'h020, 32'hFF);
        cyc(2);
        chk("irq_off", 32'(irq), 32'h0);

        // Debounce on pin 1, tick every 10 cycles
        wr(12'h024, 32'h02);
        wr(12'h028, 32'd9);
        rd_chk("dbcdiv_rb", 12'h028, 32'd9);
        pad[1] = 1'b1;
        cyc(3);
        pad[1] = 1'b0;
        cyc(25);
        rd_chk("glitch_rejected", 12'h008, 32'h0);
        pad[1] = 1'b1;
        cyc(4);
        rd_chk("dbc_not_yet", 12'h008, 32'h0);
        cyc(17);
        rd_chk("dbc_settled", 12'h008, 32'h02);

        // Async reset mid-debounce with every status bit set
        wr(12'h01C, 32'h02);
        wr(12'h018, 32'h00);
        wr(12'h014, 32'hFF);
        cyc(2);
        rd_chk("stat_all", 12'h020, 32'hFF);
        chk("irq_all", 32'(irq), 32'h1);
        pad[1] = 1'b0;
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_out", 32'(gout), 32'h0);
        chk("async_dir", 32'(gdir), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_chk("post_rst_in", 12'h008, 32'h0);
        rd_chk("post_rst_dbcen", 12'h024, 32'h0);
        rd_chk("post_rst_dbcdiv", 12'h028, 32'h0);
        rd_chk("post_rst_inten", 12'h014, 32'h0);
        rd_chk("post_rst_stat", 12'h020, 32'hFF);
        chk("post_rst_irq", 32'(irq), 32'h0);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
